// File: rtl/seq_mult_pkg.sv
// Shared types and defaults for the shift-and-add sequential multiplier.
package seq_mult_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } mult_state_t;

endpackage

// File: rtl/seq_mult_datapath.sv
// Multiplier datapath: shift registers, accumulator, iteration counter and result register.
module seq_mult_datapath
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic               commit,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [2*WIDTH-1:0] product,
  output logic               last
);

  localparam int unsigned CntW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [CntW-1:0]    cnt;

  // Full 2*WIDTH adder width, so the running sum can never overflow.
  assign acc_next = acc + (b_sh[0] ? a_sh : '0);
  assign last     = (cnt == CntW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      if (load) begin
        acc  <= '0;
        a_sh <= {{WIDTH{1'b0}}, multiplicand};
        b_sh <= multiplier;
        cnt  <= '0;
      end else if (step) begin
        acc  <= acc_next;
        a_sh <= a_sh << 1;
        b_sh <= b_sh >> 1;
        cnt  <= cnt + CntW'(1);
      end
      if (commit) begin
        product <= acc_next;
      end
    end
  end

endmodule

// File: rtl/seq_mult_core.sv
// Sequential unsigned multiplier: control FSM plus busy/done decode around the datapath.
module seq_mult_core
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               done
);

  mult_state_t state;
  logic        load;
  logic        step;
  logic        commit;
  logic        last;

  assign load   = (state == IDLE) && start;
  assign step   = (state == CALC);
  assign commit = step && last;

  // busy/done are registered alongside state so they always match the state decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= CALC;
            busy  <= 1'b1;
          end
          done <= 1'b0;
        end
        CALC: begin
          if (last) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  seq_mult_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk          (clk),
    .rst          (rst),
    .load         (load),
    .step         (step),
    .commit       (commit),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .last         (last)
  );

endmodule

// File: tb/tb_seq_mult_core.sv
// Self-checking bench for seq_mult_core: vector table, directed corner cases, random operands.
module tb_seq_mult_core;

  localparam int unsigned W = 8;

  logic           clk;
  logic           rst;
  logic           start;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic [2*W-1:0] product;
  logic           busy;
  logic           done;

  int vectors;
  int miscompares;
  int cyc;
  int done_cnt;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
  } vec_t;

  seq_mult_core #(
    .WIDTH(W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One full operation; leaves the bench just after the edge that returns to IDLE.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input string tag,
                        output int done_at);
    int lat;
    logic [2*W-1:0] exp;
    exp = 2 * W'(0) + a * b;
    exp = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    @(negedge clk);
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    @(posedge clk);
    #1;
    check({tag, " busy after accept"}, {31'd0, busy}, 32'd1);
    @(negedge clk);
    start        = 1'b0;
    multiplicand = ~a;
    multiplier   = ~b;
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    done_at = cyc;
    check({tag, " latency"}, lat, W);
    check({tag, " product"}, {16'd0, product}, {16'd0, exp});
    @(posedge clk);
    #1;
    check({tag, " done falls"}, {31'd0, done}, 32'd0);
    check({tag, " busy falls"}, {31'd0, busy}, 32'd0);
  endtask

  vec_t tbl[6];
  int   t0;
  int   t1;
  int   dc;
  logic [W-1:0] ra;
  logic [W-1:0] rb;

  initial begin
    vectors      = 0;
    miscompares  = 0;
    cyc          = 0;
    done_cnt     = 0;
    rst          = 1'b1;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;

    tbl[0] = '{a: 8'd13,  b: 8'd11,  p: 16'd143};
    tbl[1] = '{a: 8'd255, b: 8'd255, p: 16'hFE01};
    tbl[2] = '{a: 8'd0,   b: 8'd200, p: 16'd0};
    tbl[3] = '{a: 8'd200, b: 8'd0,   p: 16'd0};
    tbl[4] = '{a: 8'd1,   b: 8'd1,   p: 16'd1};
    tbl[5] = '{a: 8'd128, b: 8'd2,   p: 16'd256};

    #2;
    check("reset product", {16'd0, product}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      dc = done_cnt;
      run_op(tbl[i].a, tbl[i].b, $sformatf("vec%0d", i), t0);
      check($sformatf("vec%0d table product", i), {16'd0, product}, {16'd0, tbl[i].p});
      check($sformatf("vec%0d single done", i), done_cnt - dc, 1);
    end

    // Stray start in CALC must be ignored, not queued.
    dc = done_cnt;
    @(negedge clk);
    multiplicand = 8'd7;
    multiplier   = 8'd6;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    multiplicand = 8'd100;
    multiplier   = 8'd100;
    start        = 1'b1;
    @(negedge clk);
    start        = 1'b0;
    multiplicand = 8'd50;
    repeat (12) @(negedge clk);
    check("stray start product", {16'd0, product}, 32'd42);
    check("stray start one done", done_cnt - dc, 1);
    check("stray start idle", {31'd0, busy}, 32'd0);

    // Async reset mid-calculation clears everything without a clock edge.
    @(negedge clk);
    multiplicand = 8'd9;
    multiplier   = 8'd9;
    start        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async rst product", {16'd0, product}, 32'd0);
    check("async rst busy", {31'd0, busy}, 32'd0);
    check("async rst done", {31'd0, done}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_op(8'd3, 8'd5, "post rst", t0);

    // Back-to-back: restart in the first IDLE cycle after done.
    run_op(8'd2, 8'd3, "b2b first", t0);
    run_op(8'd4, 8'd5, "b2b second", t1);
    check("b2b done spacing", t1 - t0, W + 2);

    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      run_op(ra, rb, $sformatf("rand%0d", i), t0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_mult_core.md
Name: seq_mult_core

Overview:
- Unsigned shift-and-add sequential multiplier; the stage directly downstream of the start-button one-shot.
- Consumes the one-cycle start pulse and latches both operands on that edge.
- Iterates one multiplier bit per clock, then presents the product with a one-cycle done pulse.
- Outputs drive the board display/LED logic.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32. Product width is 2*WIDTH.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle start pulse from the one-shot stage; sampled only in IDLE.
- multiplicand  in  WIDTH  operand A; sampled on the accepting edge only.
- multiplier  in  WIDTH  operand B; sampled on the accepting edge only.
- product  out  2*WIDTH  registered result; holds its value until the next completion.
- busy  out  1  high in CALC and DONE.
- done  out  1  one-cycle pulse; high in DONE.

Behaviour:
- Reset (async, active-high):
  - state=IDLE; product=0, busy=0, done=0.
  - Internal acc, a_sh, b_sh and cnt cleared.
  - Applies immediately, including mid-calculation; the partial result is discarded and product is cleared to 0.
- States: IDLE, CALC, DONE. Encoded as an enum from the package.
- IDLE:
  - When start=1 at posedge, latch a_sh={WIDTH'0,multiplicand} (2*WIDTH wide), b_sh=multiplier, acc=0, cnt=0, then go to CALC.
  - When start=0, stay in IDLE. product holds.
- CALC, per cycle:
  - acc_next = acc + (b_sh[0] ? a_sh : 0), computed at 2*WIDTH bits; no overflow is possible.
  - a_sh <<= 1; b_sh >>= 1; cnt++.
  - When cnt==WIDTH-1, write product<=acc_next and go to DONE. Otherwise stay in CALC.
  - No early termination: always exactly WIDTH CALC cycles, even when the multiplier is 0.
- DONE: done=1 for exactly one cycle, then unconditionally go to IDLE.
- Latency:
  - Start accepted at edge k.
  - product updates and DONE is entered at edge k+WIDTH.
  - done is high during cycle k+WIDTH..k+WIDTH+1.
  - IDLE is re-entered at edge k+WIDTH+1.
  - Earliest accepted restart is edge k+WIDTH+2; the cycle after done falls is accepted.
- Handshake:
  - start asserted in CALC or DONE is ignored; it is not queued.
  - Operand changes while busy have no effect.
  - A start held high continuously is treated as a fresh request every time IDLE is reached. The one-shot upstream guarantees pulses; this block does no edge detection.
- cnt width: $clog2(WIDTH); for WIDTH a power of two, cnt wraps exactly at the terminal count.
- busy=(state!=IDLE), decoded from registered state; done=(state==DONE). Both are glitch-free Moore outputs.
- Reset deasserting while start=1 accepts the operation on the first posedge after deassertion.

Decomposition:
- Package seq_mult_pkg holds:
  - typedef enum logic [1:0] {IDLE, CALC, DONE} mult_state_t;
  - localparam default WIDTH.
- One sub-module, seq_mult_datapath, contains acc, a_sh, b_sh, cnt, the adder and the product register.
  - Control inputs: load, step, commit.
  - Status output: last (cnt==WIDTH-1).
- seq_mult_core keeps the FSM and the busy/done decode.

Test Plan:
- WIDTH=8. Reset, then pulse start with A=13, B=11 at edge k → busy=1 from k; product=143 and done=1 after edge k+8; done=0 and busy=0 after edge k+9.
- A=255, B=255 → product=65025 (0xFE01), exactly one done pulse, latency identical to the previous case.
- A=0, B=200, then A=200, B=0 → product=0 both times, each taking the full 8 CALC cycles.
- Start A=7, B=6. During CALC, pulse start again with A=100, B=100 and change the operand inputs → product=42, and only one done is produced.
- Start A=9, B=9, then assert rst asynchronously at mid-cycle of CALC cycle 4 → product=0, busy=0, done=0 immediately with no clock. After release, A=3, B=5 → product=15.
- Back-to-back: A=2, B=3, then a new start with A=4, B=5 in the first IDLE cycle after done → products 6 then 20, done pulses 10 edges apart.
